// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator feeding a small FIFO towards execute.
// Extraction is combinational; results are always registered before reaching immE.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              instrD,
    input  logic [2:0]               immSelD,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush,
    output logic [XLEN-1:0]          immE,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]             immNext;
    logic [XLEN-1:0]             sext;
    logic [DEPTH-1:0][XLEN-1:0]  mem;
    logic [PW-1:0]               wrPtr, rdPtr;
    logic [CW-1:0]               cnt;
    logic                        push, pop;
    logic                        unusedOpcode;

    assign unusedOpcode = ^instrD[6:0];

    // Signed formats start from all-copies of bit 31 and overwrite the low field.
    always_comb begin
        sext    = {XLEN{instrD[31]}};
        immNext = '0;
        case (immSelD)
            3'b000: begin
                immNext        = sext;
                immNext[11:0]  = instrD[31:20];
            end
            3'b001: begin
                immNext        = sext;
                immNext[12:0]  = {instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            end
            3'b010: begin
                immNext        = sext;
                immNext[20:0]  = {instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            end
            3'b011: begin
                immNext        = sext;
                immNext[11:0]  = {instrD[31:25], instrD[11:7]};
            end
            3'b100: begin
                immNext        = sext;
                immNext[31:0]  = {instrD[31:12], 12'b0};
            end
            3'b101: immNext[4:0] = instrD[19:15];
            3'b110: begin
                if (XLEN == 64) immNext[5:0] = instrD[25:20];
                else            immNext[4:0] = instrD[24:20];
            end
            default: immNext = '0;
        endcase
    end

    assign valid_o = (cnt != '0);
    assign ready_o = (cnt != CW'(DEPTH));
    assign count   = cnt;
    assign immE    = valid_o ? mem[rdPtr] : '0;

    // Flush wins over both handshakes, so gate them here once.
    assign push = valid_i & ready_o & ~flush;
    assign pop  = valid_o & ready_i & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= immNext;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32 and XLEN=64 instances driven in lockstep by one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instrD;
    logic [2:0]  immSelD;
    logic        valid_i, flush, ready_i;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [1:0]  cnt32, cnt64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u32 (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .immSelD(immSelD),
        .valid_i(valid_i), .ready_o(rdy32), .flush(flush), .immE(imm32),
        .valid_o(vld32), .ready_i(ready_i), .count(cnt32));

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u64 (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .immSelD(immSelD),
        .valid_i(valid_i), .ready_o(rdy64), .flush(flush), .immE(imm64),
        .valid_o(vld64), .ready_i(ready_i), .count(cnt64));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] exp32;
        logic [63:0] exp64;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel);
        valid_i = v;
        instrD  = ins;
        immSelD = sel;
    endtask

    // Status of the 32-bit instance; the 64-bit one sees identical handshakes.
    task automatic checkState(input string name, input int c, input logic [31:0] imm);
        check({name, ".count"},   64'(cnt32), 64'(c));
        check({name, ".count64"}, 64'(cnt64), 64'(c));
        check({name, ".ready"},   64'(rdy32), 64'(c != 2));
        check({name, ".valid"},   64'(vld32), 64'(c != 0));
        check({name, ".immE"},    64'(imm32), 64'(imm));
    endtask

    initial begin
        // B 0xFE000FE3 encodes -2 (instr[8]=1); 0xFE000EE3 is the -4 branch.
        vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
        vecs[1]  = '{32'hFE20AE23, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        vecs[2]  = '{32'hFE000FE3, 3'b001, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
        vecs[3]  = '{32'hFE000EE3, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        vecs[4]  = '{32'h123450B7, 3'b100, 32'h12345000, 64'h00000000_12345000};
        vecs[5]  = '{32'h800F8073, 3'b101, 32'h0000001F, 64'h00000000_0000001F};
        vecs[6]  = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h00000000_00000000};
        vecs[7]  = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF_80000000};
        vecs[8]  = '{32'h83F00013, 3'b110, 32'h0000001F, 64'h00000000_0000003F};
        vecs[9]  = '{32'h8000006F, 3'b010, 32'hFFF00000, 64'hFFFFFFFF_FFF00000};
        vecs[10] = '{32'h7FFFF06F, 3'b010, 32'h000FFFFE, 64'h00000000_000FFFFE};
        vecs[11] = '{32'h7FF00093, 3'b000, 32'h000007FF, 64'h00000000_000007FF};
        vecs[12] = '{32'h00000F23, 3'b011, 32'h0000001E, 64'h00000000_0000001E};

        rst_n = 1'b0; flush = 1'b0; ready_i = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        #12;
        checkState("reset", 0, 32'h0);
        check("reset.valid64", 64'(vld64), 64'h0);
        check("reset.immE64",  imm64, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // Pop request while empty is ignored.
        ready_i = 1'b1;
        @(negedge clk);
        checkState("emptyPop", 0, 32'h0);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].instr, vecs[i].sel);
            @(negedge clk);
            drive(1'b0, 32'h0, 3'b000);
            check($sformatf("vec%0d.valid", i), 64'(vld32 & vld64), 64'h1);
            check($sformatf("vec%0d.imm32", i), 64'(imm32), 64'(vecs[i].exp32));
            check($sformatf("vec%0d.imm64", i), imm64, vecs[i].exp64);
            check($sformatf("vec%0d.count", i), 64'(cnt32), 64'h1);
            @(negedge clk);
            check($sformatf("vec%0d.drained", i), 64'(cnt32), 64'h0);
        end

        // Back-pressure: three pushes into a 2-deep buffer with execute stalled.
        ready_i = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000);
        @(negedge clk); checkState("bp1", 1, 32'h1);
        drive(1'b1, 32'h00200093, 3'b000);
        @(negedge clk); checkState("bp2", 2, 32'h1);
        drive(1'b1, 32'h00300093, 3'b000);
        @(negedge clk); checkState("bp3held", 2, 32'h1);
        ready_i = 1'b1;
        @(negedge clk); checkState("fullPop", 1, 32'h2);
        @(negedge clk); checkState("bpPushPop", 1, 32'h3);
        drive(1'b0, 32'h0, 3'b000);
        @(negedge clk); checkState("bpDrained", 0, 32'h0);

        // Flush with a full buffer and a concurrent push.
        ready_i = 1'b0;
        drive(1'b1, 32'h00400093, 3'b000);
        @(negedge clk);
        drive(1'b1, 32'h00500093, 3'b000);
        @(negedge clk); checkState("preFlush", 2, 32'h4);
        drive(1'b1, 32'h00600093, 3'b000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkState("flushFull", 0, 32'h0);
        check("flush.immE64", imm64, 64'h0);
        drive(1'b1, 32'h00700093, 3'b000);
        @(negedge clk); checkState("postFlush1", 1, 32'h7);
        drive(1'b1, 32'h00800093, 3'b000);
        @(negedge clk); checkState("postFlush2", 2, 32'h7);
        drive(1'b0, 32'h0, 3'b000);
        ready_i = 1'b1;
        @(negedge clk); checkState("postFlushPop1", 1, 32'h8);
        @(negedge clk); checkState("postFlushPop2", 0, 32'h0);

        // Flush while push would otherwise be accepted: the push is dropped.
        ready_i = 1'b0;
        drive(1'b1, 32'h00900093, 3'b000);
        @(negedge clk);
        drive(1'b1, 32'h00A00093, 3'b000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        checkState("flushDrop", 0, 32'h0);

        // Asynchronous reset between edges with one entry held.
        drive(1'b1, 32'h00B00093, 3'b000);
        @(negedge clk);
        drive(1'b0, 32'h0, 3'b000);
        checkState("preReset", 1, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        checkState("asyncReset", 0, 32'h0);
        check("asyncReset.valid64", 64'(vld64), 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); checkState("afterReset", 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
